uart_word_loader: RTL and testbench
===================================

Name: uart_word_loader

Overview:
- Serial program loader that sits directly upstream of the instruction ROM write port.
- Receives 8N1 UART bytes on a single pin and assembles groups of 4 bytes into 32-bit little-endian words.
- Presents each word with an auto-incrementing word address and a one-cycle write strobe.
- Active only while the loader-enable switch is on; the CPU is held in reset over the same window.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); minimum 4.
- MAX_WORDS, 64, ROM depth in words; words arriving at or beyond this index are dropped.

Ports:
- clk  input  1  system clock (undivided clkIn domain).
- rst  input  1  synchronous, active-high reset.
- enable  input  1  loader enable, already debounced; low = loader idle and cleared.
- uart_rx  input  1  raw asynchronous serial input; idle high.
- addr  output  32  word address of current write; zero-extended, counts 0..MAX_WORDS-1.
- data  output  32  assembled word; first received byte lands in [7:0].
- wr  output  1  one-cycle write strobe; addr/data valid while high.
- busy  output  1  high while a frame is being received (state != IDLE).
- frame_err  output  1  one-cycle pulse when a stop bit samples 0.
- overflow  output  1  sticky; set when a complete word arrives with addr == MAX_WORDS.

Behaviour:
- Reset (rst=1 at posedge clk): all outputs 0; 2-flop synchronizer regs preset to 1; FSM = IDLE; bit and byte counters 0.
- Clear: enable=0 acts as a synchronous clear equal to reset (except synchronizer). Any byte or word in progress is aborted. A later enable=1 restarts at addr 0.
- Input path: uart_rx passes through a 2-flop synchronizer to rx_s. All sampling uses rx_s.
- Receive FSM states: IDLE, START, DATA, STOP. One cycle counter cnt runs 0..CLKS_PER_BIT-1.
  - IDLE: when rx_s==0, go to START with cnt=0.
  - START: when cnt == CLKS_PER_BIT/2-1 (integer division), sample rx_s.
    - rx_s==0: go to DATA, cnt=0, bit_idx=0.
    - rx_s==1: glitch; return to IDLE with no error.
  - DATA: when cnt == CLKS_PER_BIT-1, shift rx_s into the byte LSB-first and set cnt=0. After bit_idx 7, go to STOP.
  - STOP: when cnt == CLKS_PER_BIT-1, sample rx_s.
    - rx_s==1: byte accepted.
    - rx_s==0: pulse frame_err for one cycle; discard the byte; the byte counter is unchanged.
    - Either way, return to IDLE.
- Word assembly: byte k (k=0..3) of the current word is written to data[8k+7:8k] on acceptance. data bits are updated in place; the other bytes keep their old values until overwritten.
- Word complete (4th byte accepted), in the cycle after the STOP sample:
  - If addr < MAX_WORDS: wr=1 for exactly one cycle with the current addr and full data. addr increments by 1 in the cycle after wr.
  - If addr == MAX_WORDS: no wr; overflow set and held until rst or enable=0; addr stays at MAX_WORDS.
  - Byte counter returns to 0 in both cases.
- Hold behaviour:
  - data holds the last word after wr.
  - addr after the last write equals the number of words written.
  - No back-pressure: the consumer must accept wr in the single cycle it is high.
- Latency: from the start-bit falling edge on uart_rx to wr high is about 9.5·CLKS_PER_BIT + 3 cycles for the 4th byte (2 synchronizer + 1 registered strobe).
- Simultaneous events:
  - enable falling in the same cycle a word completes: the clear wins and no wr is issued.
  - rst has priority over everything.
- Back-to-back frames: a new start bit is detected in IDLE on the cycle after STOP, so no gap is required between bytes.

Test Plan (CLKS_PER_BIT=8, MAX_WORDS=4):
- Reset and basic load: rst, then enable=1; send bytes 0x13,0x05,0x10,0x00 → exactly one wr pulse with addr=0, data=0x00100513; addr reads 1 afterwards; frame_err=0, overflow=0.
- Multi-word: send 8 bytes 0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE back-to-back with no idle gap → wr at addr 0 data 0x12345678, then wr at addr 1 data 0xDEADBEEF; final addr=2.
- Framing error: send 0xAA with the stop bit driven 0, then 0x11,0x22,0x33,0x44 → one frame_err pulse and no wr for 0xAA; the next word is written as 0x44332211 at addr 0.
- Glitch rejection: pull uart_rx low for 2 cycles, then high → FSM returns to IDLE; no frame_err, no byte accepted; busy drops within CLKS_PER_BIT/2+3 cycles.
- Abort and overflow: send 2 bytes, drop enable for 1 cycle, raise it, send 20 bytes of 0x01 → words written at addr 0..3 (data 0x01010101); 5th word produces no wr and overflow=1; drop enable → overflow=0, addr=0.

Source files
------------

// File: rtl/uart_word_loader.sv
// 8N1 UART receiver that packs four bytes into little-endian 32-bit words
// and writes them to an instruction ROM with an auto-incrementing address.
module uart_word_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_WORDS    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        uart_rx,
    output logic [31:0] addr,
    output logic [31:0] data,
    output logic        wr,
    output logic        busy,
    output logic        frame_err,
    output logic        overflow
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic             rx_meta_q, rx_s_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [31:0]      data_q, data_d;
    logic [31:0]      addr_q, addr_d;
    logic             wr_q, wr_d;
    logic             frame_err_q, frame_err_d;
    logic             overflow_q, overflow_d;

    // Synchronizer idles high and is deliberately untouched by enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            byte_idx_q  <= '0;
            data_q      <= '0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            byte_idx_q  <= byte_idx_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        byte_idx_d  = byte_idx_q;
        data_d      = data_q;
        addr_d      = addr_q;
        wr_d        = 1'b0;
        frame_err_d = 1'b0;
        overflow_d  = overflow_q;

        // Address advances in the cycle after the strobe so wr sees the old one.
        if (wr_q) addr_d = addr_q + 32'd1;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shreg_d   = {rx_s_q, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s_q) begin
                        data_d[{byte_idx_q, 3'b000} +: 8] = shreg_q;
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            if (addr_q < 32'(MAX_WORDS)) wr_d = 1'b1;
                            else                         overflow_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!enable) begin
            state_d     = IDLE;
            cnt_d       = '0;
            bit_idx_d   = '0;
            shreg_d     = '0;
            byte_idx_d  = '0;
            data_d      = '0;
            addr_d      = '0;
            wr_d        = 1'b0;
            frame_err_d = 1'b0;
            overflow_d  = 1'b0;
        end
    end

    assign addr      = addr_q;
    assign data      = data_q;
    assign wr        = wr_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_uart_word_loader.sv
// Scoreboard bench for uart_word_loader: byte-level reference model queues
// expected ROM writes, a negedge monitor checks every wr pulse against them.
module tb_uart_word_loader;
    localparam int CPB  = 8;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst, enable, uart_rx;
    logic [31:0] addr, data;
    logic        wr, busy, frame_err, overflow;

    uart_word_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .uart_rx(uart_rx),
        .addr(addr), .data(data), .wr(wr), .busy(busy),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [7:0]  pend_bytes[$];
    int          model_addr = 0;
    bit          model_ovf  = 1'b0;
    int          exp_fe     = 0;
    int          fe_seen    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a received byte either joins the pending word or, as
    // the fourth byte, turns it into a ROM write (or an overflow past MAXW).
    task automatic model_byte(input logic [7:0] b);
        pend_bytes.push_back(b);
        if (pend_bytes.size() == 4) begin
            if (model_addr < MAXW) begin
                exp_addr_q.push_back(32'(model_addr));
                exp_data_q.push_back({pend_bytes[3], pend_bytes[2], pend_bytes[1], pend_bytes[0]});
                model_addr++;
            end else begin
                model_ovf = 1'b1;
            end
            pend_bytes.delete();
        end
    endtask

    task automatic model_clear();
        pend_bytes.delete();
        model_addr = 0;
        model_ovf  = 1'b0;
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        if (good_stop) model_byte(b);
        else           exp_fe++;
        uart_rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            hold(CPB);
        end
        uart_rx = good_stop;
        hold(CPB);
        uart_rx = 1'b1;
        if (!good_stop) hold(2 * CPB);
    endtask

    task automatic clear_loader();
        enable = 1'b0;
        hold(1);
        model_clear();
        enable = 1'b1;
        hold(1);
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, "_addr"}, addr, 32'(model_addr));
        check({tag, "_overflow"}, {31'b0, overflow}, {31'b0, model_ovf});
        check({tag, "_frame_err_count"}, 32'(fe_seen), 32'(exp_fe));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (frame_err) fe_seen++;
        if (wr) begin
            if (exp_addr_q.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                check("wr_addr", addr, exp_addr_q.pop_front());
                check("wr_data", data, exp_data_q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] seq8 [8];
        rst = 1'b1; enable = 1'b0; uart_rx = 1'b1;
        hold(3);
        @(negedge clk);
        check("rst_addr", addr, 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_flags", {28'b0, wr, busy, frame_err, overflow}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        enable = 1'b1;
        hold(2);

        // Basic single word
        send_byte(8'h13, 1'b1); send_byte(8'h05, 1'b1);
        send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
        hold(CPB);
        check_state("basic");
        @(negedge clk);
        check("basic_data_hold", data, 32'h0010_0513);
        @(posedge clk); #1;

        // Two words back to back
        clear_loader();
        seq8 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 8; i++) send_byte(seq8[i], 1'b1);
        hold(CPB);
        check_state("multi");

        // Framing error then a good word
        clear_loader();
        send_byte(8'hAA, 1'b0);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        hold(CPB);
        check_state("framing");

        // Short low glitch must not start a byte
        clear_loader();
        uart_rx = 1'b0;
        hold(2);
        uart_rx = 1'b1;
        hold(CPB / 2 + 3 - 2);
        @(negedge clk);
        check("glitch_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        hold(CPB);
        check_state("glitch");

        // Abort mid-word, then fill the ROM and overflow
        send_byte(8'h5A, 1'b1); send_byte(8'hA5, 1'b1);
        clear_loader();
        for (int i = 0; i < 20; i++) send_byte(8'h01, 1'b1);
        hold(CPB);
        check_state("overflow");
        @(negedge clk);
        check("overflow_data", data, 32'h0101_0101);
        @(posedge clk); #1;
        enable = 1'b0;
        hold(1);
        model_clear();
        @(negedge clk);
        check("disable_overflow", {31'b0, overflow}, 32'd0);
        check("disable_addr", addr, 32'd0);
        @(posedge clk); #1;
        enable = 1'b1;
        hold(1);

        // Random bytes, occasional bad stop bits and idle gaps
        for (int i = 0; i < 16; i++) begin
            logic [7:0] rb;
            bit good;
            int gap;
            rb   = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            gap  = $urandom_range(0, 2);
            send_byte(rb, good);
            if (gap > 0) hold(gap * CPB);
        end
        hold(2 * CPB);
        check_state("random");

        check("scoreboard_empty", 32'(exp_addr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
